// File: rtl/obi_sdp_ram_pkg.sv
// Shared types and helpers for the OBI-to-simple-dual-port BRAM controller.
// Response tags travel down a fixed-latency pipeline alongside the RAM read.
package obi_sdp_ram_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    typedef struct packed {
        logic valid;
        logic is_instr;
        logic is_write;
    } rsp_tag_t;

    // A data write and an instruction read can complete together, so each stage carries two tags.
    typedef struct packed {
        rsp_tag_t rd;
        rsp_tag_t wr;
    } rsp_stage_t;

    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Request/grant bit 0 is the data port, bit 1 the instruction port.
// r_prio_q = 0 favours data, 1 favours instr; it flips to the loser only on a contended cycle.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_prio_q;
    logic w_prio_next;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_prio_q <= 1'b0;
        end else begin
            r_prio_q <= w_prio_next;
        end
    end

    always_comb begin
        o_gnt       = i_req;
        w_prio_next = r_prio_q;
        if (i_req == 2'b11) begin
            o_gnt       = r_prio_q ? 2'b10 : 2'b01;
            w_prio_next = ~r_prio_q;
        end
    end

endmodule

// File: rtl/obi_sdp_ram_ctrl.sv
// Shares one simple-dual-port byte-write BRAM between the instruction (read-only) and data OBI ports.
// Writes use port A directly; reads contend for port B and return after a fixed READ_LATENCY.
module obi_sdp_ram_ctrl
    import obi_sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 17,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addra_o,
    output logic [31:0]           ram_dina_o,
    output logic [3:0]            ram_wea_o,
    output logic [ADDR_WIDTH-1:0] ram_addrb_o,
    output logic                  ram_enb_o,
    output logic                  ram_rstb_o,
    output logic                  ram_regceb_o,
    input  logic [31:0]           ram_doutb_i
);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("obi_sdp_ram_ctrl: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [31:0]           w_instr_word_full;
    logic [31:0]           w_data_word_full;
    logic [ADDR_WIDTH-1:0] w_instr_word;
    logic [ADDR_WIDTH-1:0] w_data_word;
    logic                  w_data_wr;
    logic                  w_data_rd;
    logic [1:0]            w_arb_gnt;
    logic                  w_instr_gnt;
    logic                  w_data_rd_gnt;
    logic                  w_data_wr_gnt;
    logic                  w_rd_gnt;
    rsp_stage_t            w_pipe_in;
    rsp_stage_t            w_stage_d [READ_LATENCY];
    rsp_stage_t            r_pipe    [READ_LATENCY];
    rsp_stage_t            w_tail;
    logic                  w_data_rd_vld;
    logic                  w_unused;

    // Upper address bits are dropped so the address wraps modulo the RAM depth.
    assign w_instr_word_full = byte_to_word(instr_addr_i);
    assign w_data_word_full  = byte_to_word(data_addr_i);
    assign w_instr_word      = w_instr_word_full[ADDR_WIDTH-1:0];
    assign w_data_word       = w_data_word_full[ADDR_WIDTH-1:0];

    assign w_data_wr = data_req_i & data_we_i;
    assign w_data_rd = data_req_i & ~data_we_i;

    rr_arb2 u_rr_arb2 (
        .i_clk  (clk_i),
        .i_srst (rst_i),
        .i_req  ({instr_req_i, w_data_rd}),
        .o_gnt  (w_arb_gnt)
    );

    assign w_instr_gnt   = ~rst_i & w_arb_gnt[1];
    assign w_data_rd_gnt = ~rst_i & w_arb_gnt[0];
    assign w_data_wr_gnt = ~rst_i & w_data_wr;
    assign w_rd_gnt      = w_instr_gnt | w_data_rd_gnt;

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_rd_gnt | w_data_wr_gnt;

    assign ram_addra_o = w_data_word;
    assign ram_dina_o  = data_wdata_i;
    assign ram_wea_o   = w_data_wr_gnt ? data_be_i : 4'h0;

    assign ram_addrb_o = w_instr_gnt ? w_instr_word : w_data_word;
    assign ram_enb_o   = w_rd_gnt;
    assign ram_rstb_o  = rst_i;

    always_comb begin
        w_pipe_in             = '0;
        w_pipe_in.rd.valid    = w_rd_gnt;
        w_pipe_in.rd.is_instr = w_instr_gnt;
        w_pipe_in.wr.valid    = w_data_wr_gnt;
        w_pipe_in.wr.is_write = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_stage_d[gi] = w_pipe_in;
            end else begin : g_body
                assign w_stage_d[gi] = r_pipe[gi-1];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_pipe[gi] <= '0;
                end else begin
                    r_pipe[gi] <= w_stage_d[gi];
                end
            end
        end

        // With an output register, RAM data moves into it the cycle after the read enable.
        if (READ_LATENCY == 2) begin : g_regce
            assign ram_regceb_o = ~rst_i & r_pipe[0].rd.valid;
        end else begin : g_no_regce
            assign ram_regceb_o = 1'b0;
        end
    endgenerate

    assign w_tail = r_pipe[READ_LATENCY-1];

    assign instr_rvalid_o = ~rst_i & w_tail.rd.valid & w_tail.rd.is_instr;
    assign w_data_rd_vld  = ~rst_i & w_tail.rd.valid & ~w_tail.rd.is_instr;
    assign data_rvalid_o  = w_data_rd_vld | (~rst_i & w_tail.wr.valid);
    assign instr_rdata_o  = instr_rvalid_o ? ram_doutb_i : 32'h0;
    assign data_rdata_o   = w_data_rd_vld ? ram_doutb_i : 32'h0;

    assign w_unused = ^{w_instr_word_full[31:ADDR_WIDTH], w_data_word_full[31:ADDR_WIDTH],
                        w_tail.rd.is_write, w_tail.wr.is_instr, w_tail.wr.is_write};

endmodule

// File: tb/tb_obi_sdp_ram_ctrl.sv
// Bench for obi_sdp_ram_ctrl: one instance per read latency, each with its own BRAM model,
// checked every cycle against a word-level reference memory and a response schedule.
module tb_obi_sdp_ram_ctrl;

    localparam int          AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          VW    = 107 + 2 * AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ireq, dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, dwdata;

    logic          ig1, dg1, iv1, dv1, enb1, rstb1, regceb1;
    logic [31:0]   ird1, drd1, dina1, dout1;
    logic [3:0]    wea1;
    logic [AW-1:0] addra1, addrb1;
    logic          ig2, dg2, iv2, dv2, enb2, rstb2, regceb2;
    logic [31:0]   ird2, drd2, dina2, dout2, q2a;
    logic [3:0]    wea2;
    logic [AW-1:0] addra2, addrb2;

    obi_sdp_ram_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq), .instr_gnt_o(ig1), .instr_addr_i(iaddr),
        .instr_rvalid_o(iv1), .instr_rdata_o(ird1),
        .data_req_i(dreq), .data_gnt_o(dg1), .data_we_i(dwe), .data_be_i(dbe),
        .data_addr_i(daddr), .data_wdata_i(dwdata), .data_rvalid_o(dv1), .data_rdata_o(drd1),
        .ram_addra_o(addra1), .ram_dina_o(dina1), .ram_wea_o(wea1), .ram_addrb_o(addrb1),
        .ram_enb_o(enb1), .ram_rstb_o(rstb1), .ram_regceb_o(regceb1), .ram_doutb_i(dout1)
    );

    obi_sdp_ram_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq), .instr_gnt_o(ig2), .instr_addr_i(iaddr),
        .instr_rvalid_o(iv2), .instr_rdata_o(ird2),
        .data_req_i(dreq), .data_gnt_o(dg2), .data_we_i(dwe), .data_be_i(dbe),
        .data_addr_i(daddr), .data_wdata_i(dwdata), .data_rvalid_o(dv2), .data_rdata_o(drd2),
        .ram_addra_o(addra2), .ram_dina_o(dina2), .ram_wea_o(wea2), .ram_addrb_o(addrb2),
        .ram_enb_o(enb2), .ram_rstb_o(rstb2), .ram_regceb_o(regceb2), .ram_doutb_i(dout2)
    );

    // BRAM models: read-first, byte write enables, optional output register.
    logic [31:0] ram1 [DEPTH];
    logic [31:0] ram2 [DEPTH];

    always @(posedge clk) begin
        if (enb1) dout1 = ram1[addrb1];
        for (int b = 0; b < 4; b++)
            if (wea1[b]) ram1[addra1][8*b +: 8] = dina1[8*b +: 8];
    end

    always @(posedge clk) begin
        if (rstb2) dout2 = 32'h0;
        else if (regceb2) dout2 = q2a;
        if (enb2) q2a = ram2[addrb2];
        for (int b = 0; b < 4; b++)
            if (wea2[b]) ram2[addra2][8*b +: 8] = dina2[8*b +: 8];
    end

    // Reference model state
    logic [31:0]  mem_m [DEPTH];
    logic         prio_m;
    int unsigned  cyc;
    logic         ent_iv [16];
    logic         ent_dv [16];
    logic         ent_rd [16];
    logic [31:0]  ent_id [16];
    logic [31:0]  ent_dd [16];
    logic         pend_rst, pend_wr, pend_contend, pend_iwon;
    logic [3:0]   pend_be;
    int unsigned  pend_wa;
    logic [31:0]  pend_wd;
    logic [VW-1:0] exp1, exp2, obs1, obs2;
    int n_checks = 0;
    int n_fail   = 0;

    assign obs1 = {ig1, dg1, wea1, (wea1 != 4'h0) ? addra1 : {AW{1'b0}}, (wea1 != 4'h0) ? dina1 : 32'h0,
                   enb1, enb1 ? addrb1 : {AW{1'b0}}, regceb1, rstb1,
                   iv1, (iv1 || rst) ? ird1 : 32'h0, dv1, (dv1 || rst) ? drd1 : 32'h0};
    assign obs2 = {ig2, dg2, wea2, (wea2 != 4'h0) ? addra2 : {AW{1'b0}}, (wea2 != 4'h0) ? dina2 : 32'h0,
                   enb2, enb2 ? addrb2 : {AW{1'b0}}, regceb2, rstb2,
                   iv2, (iv2 || rst) ? ird2 : 32'h0, dv2, (dv2 || rst) ? drd2 : 32'h0};

    function automatic int unsigned word_of(input logic [31:0] a);
        int unsigned q;
        q = a;
        return (q / 4) % DEPTH;
    endfunction

    // Advance the model across a clock edge: apply last cycle's write, rotate priority, honour reset.
    task automatic commit();
        if (pend_rst) begin
            prio_m = 1'b0;
            for (int i = 0; i < 16; i++) begin
                ent_iv[i] = 1'b0; ent_dv[i] = 1'b0; ent_rd[i] = 1'b0;
            end
        end else begin
            if (pend_wr)
                for (int b = 0; b < 4; b++)
                    if (pend_be[b]) mem_m[pend_wa][8*b +: 8] = pend_wd[8*b +: 8];
            if (pend_contend) prio_m = !pend_iwon;
        end
        cyc++;
    endtask

    // Expected outputs for the current cycle; responses come from the grant schedule LAT cycles back.
    task automatic predict();
        logic g_i, g_dr, g_dw, drq, wr_vis;
        int unsigned ia, wa, p1, p2, pc;
        logic [AW-1:0] e_addra, e_addrb;
        logic [31:0] e_dina;
        ia  = word_of(iaddr);
        wa  = word_of(daddr);
        drq = dreq && !dwe;
        g_i  = !rst && ireq && (!drq || prio_m);
        g_dr = !rst && drq && (!ireq || !prio_m);
        g_dw = !rst && dreq && dwe;
        wr_vis  = g_dw && (dbe != 4'h0);
        e_addra = wr_vis ? AW'(wa) : {AW{1'b0}};
        e_dina  = wr_vis ? dwdata : 32'h0;
        e_addrb = g_i ? AW'(ia) : (g_dr ? AW'(wa) : {AW{1'b0}});
        p1 = (cyc - 1) % 16;
        p2 = (cyc - 2) % 16;
        pc = cyc % 16;
        exp1 = {g_i, g_dw || g_dr, g_dw ? dbe : 4'h0, e_addra, e_dina, g_i || g_dr, e_addrb, 1'b0, rst,
                !rst && ent_iv[p1], (!rst && ent_iv[p1]) ? ent_id[p1] : 32'h0,
                !rst && ent_dv[p1], (!rst && ent_dv[p1]) ? ent_dd[p1] : 32'h0};
        exp2 = {g_i, g_dw || g_dr, g_dw ? dbe : 4'h0, e_addra, e_dina, g_i || g_dr, e_addrb,
                !rst && ent_rd[p1], rst,
                !rst && ent_iv[p2], (!rst && ent_iv[p2]) ? ent_id[p2] : 32'h0,
                !rst && ent_dv[p2], (!rst && ent_dv[p2]) ? ent_dd[p2] : 32'h0};
        ent_iv[pc] = g_i;
        ent_id[pc] = mem_m[ia];
        ent_dv[pc] = g_dw || g_dr;
        ent_dd[pc] = g_dw ? 32'h0 : mem_m[wa];
        ent_rd[pc] = g_i || g_dr;
        pend_rst = rst; pend_wr = g_dw; pend_wa = wa; pend_be = dbe; pend_wd = dwdata;
        pend_contend = !rst && ireq && drq;
        pend_iwon = g_i;
        $display("cyc=%0d rst=%b instr_req=%b gnt=%b data_req=%b we=%b gnt=%b iw=%0d dw=%0d",
                 cyc, rst, ireq, g_i, dreq, dwe, g_dw || g_dr, ia, wa);
    endtask

    task automatic do_cycle(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                            input logic we, input logic [3:0] be, input logic [31:0] da,
                            input logic [31:0] wd);
        @(posedge clk);
        commit();
        #1;
        rst = r; ireq = ir; iaddr = ia; dreq = dr; dwe = we; dbe = be; daddr = da; dwdata = wd;
        @(negedge clk);
        predict();
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            do_cycle(1'b1, 1'b1, $urandom, 1'b1, s[0], 4'hF, $urandom, $urandom);
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL reset lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL reset lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            n_checks++;
            if ({ig1, dg1, ig2, dg2, wea1, enb1, iv1, dv1} !== 11'h0) begin
                n_fail++; $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc, {ig1, dg1, ig2, dg2, wea1, enb1, iv1, dv1});
            end
        end
    endtask

    task automatic test_write_read();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
                1:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
                default: do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL write_read lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL write_read lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            if (s == 1) begin
                n_checks++;
                if ({dv1, drd1} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL write_rsp got=%b/%h exp=1/0", dv1, drd1); end
            end
            if (s == 2) begin
                n_checks++;
                if ({dv1, drd1} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL read_rsp got=%b/%h exp=1/deadbeef", dv1, drd1); end
            end
        end
    endtask

    task automatic test_round_robin();
        for (int s = 0; s < 7; s++) begin
            if (s == 0)     do_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            else if (s < 5) do_cycle(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 4'h0, $urandom, 32'h0);
            else            do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL round_robin lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL round_robin lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            if (s >= 1 && s <= 4) begin
                n_checks++;
                if ({ig1, dg1} !== (s[0] ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rr_order step=%0d got=%b exp=%b", s, {ig1, dg1}, s[0] ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_partial_write();
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h44, 32'h11223344);
                1:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h45, 32'h0000AB00);
                2:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h47, 32'h0);
                default: do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL partial lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL partial lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            if (s == 3) begin
                n_checks++;
                if ({dv1, drd1} !== {1'b1, 32'h1122AB44}) begin n_fail++; $display("FAIL byte_enable got=%b/%h exp=1/1122ab44", dv1, drd1); end
            end
        end
    endtask

    task automatic test_same_cycle();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
                1:       do_cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678);
                2:       do_cycle(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                default: do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL same_cycle lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL same_cycle lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            if (s == 1) begin
                n_checks++;
                if ({ig1, dg1} !== 2'b11) begin n_fail++; $display("FAIL both_granted got=%b exp=11", {ig1, dg1}); end
            end
            if (s == 2) begin
                n_checks++;
                if ({iv1, ird1} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("FAIL read_first got=%b/%h exp=1/cafef00d", iv1, ird1); end
            end
            if (s == 3) begin
                n_checks++;
                if ({iv1, ird1} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL read_after_write got=%b/%h exp=1/12345678", iv1, ird1); end
            end
        end
    endtask

    task automatic test_lat2_back_to_back();
        logic [1:0] tbl [6];
        tbl = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
        for (int s = 0; s < 6; s++) begin
            if (s < 3) do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'(4 * s), 32'h0);
            else       do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL lat2_b2b lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL lat2_b2b lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            n_checks++;
            if ({regceb2, dv2} !== tbl[s]) begin
                n_fail++; $display("FAIL regce_timing step=%0d got=%b exp=%b", s, {regceb2, dv2}, tbl[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 7; s++) begin
            case (s)
                0:       do_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                1, 4:    do_cycle(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 4'h0, $urandom, 32'h0);
                2:       do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, $urandom, 32'h0);
                3:       do_cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 4'hF, $urandom, $urandom);
                default: do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL reset_mid lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL reset_mid lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
            if (s == 3) begin
                n_checks++;
                if ({ig1, dg1, iv1, dv1, wea1, enb1, regceb1, regceb2, ird1, drd1, dv2, iv2} !== 77'h0) begin
                    n_fail++; $display("FAIL reset_mid_zero got=%b%b%b%b %h %h exp=0", ig1, dg1, iv1, dv1, ird1, drd1);
                end
            end
            if (s == 4) begin
                n_checks++;
                if ({ig1, dg1, dv2} !== 3'b010) begin n_fail++; $display("FAIL prio_after_reset got=%b exp=010", {ig1, dg1, dv2}); end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 80; s++) begin
            do_cycle($urandom_range(0, 19) == 0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                     4'($urandom), $urandom_range(0, 255) | ($urandom << 10), $urandom);
            n_checks++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL random lat1 cyc=%0d got=%h exp=%h", cyc, obs1, exp1); end
            n_checks++;
            if (obs2 !== exp2) begin n_fail++; $display("FAIL random lat2 cyc=%0d got=%h exp=%h", cyc, obs2, exp2); end
        end
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; dbe = 4'h0;
        iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [31:0] v;
            v = $urandom;
            ram1[i] = v; ram2[i] = v; mem_m[i] = v;
        end
        for (int i = 0; i < 16; i++) begin
            ent_iv[i] = 1'b0; ent_dv[i] = 1'b0; ent_rd[i] = 1'b0;
            ent_id[i] = 32'h0; ent_dd[i] = 32'h0;
        end
        prio_m = 1'b0; cyc = 16;
        pend_rst = 1'b1; pend_wr = 1'b0; pend_contend = 1'b0; pend_iwon = 1'b0;
        pend_be = 4'h0; pend_wa = 0; pend_wd = 32'h0;

        test_reset();
        test_write_read();
        test_round_robin();
        test_partial_write();
        test_same_cycle();
        test_lat2_back_to_back();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
